// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial CLA adder: state encoding, default width, clog2 helper.
package cla_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int NIB_BITS      = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; also exports the carry into bit 3 for overflow detection.
module cla4_slice
    import cla_seq_pkg::*;
(
    input  logic [NIB_BITS-1:0] a,
    input  logic [NIB_BITS-1:0] b,
    input  logic                ci,
    output logic [NIB_BITS-1:0] s,
    output logic                co,
    output logic                c3
);

    logic [NIB_BITS-1:0] g_s;
    logic [NIB_BITS-1:0] p_s;
    logic [NIB_BITS:0]   c_s;

    // Generate/propagate terms and flattened lookahead carries
    always_comb begin
        g_s    = a & b;
        p_s    = a ^ b;
        c_s[0] = ci;
        c_s[1] = g_s[0] | (p_s[0] & ci);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & ci);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);
        s      = p_s ^ c_s[NIB_BITS-1:0];
        co     = c_s[4];
        c3     = c_s[3];
    end

endmodule

// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder that time-shares one cla4_slice, one nibble per clock, LSB first.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_nibble_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIB_BITS;
    localparam int CNT_W = (clog2(NIB) < 1) ? 1 : clog2(NIB);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NIB-1:0][NIB_BITS-1:0]   a_q, a_d;
    logic [NIB-1:0][NIB_BITS-1:0]   b_q, b_d;
    logic [NIB-1:0][NIB_BITS-1:0]   s_q, s_d;
    logic                           carry_q, carry_d;
    logic                           co_q, co_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
`ifdef CLA_SEQ_OVF_EN
    logic                           ovf_q, ovf_d;
    logic                           nib_c3_s;
`else
    logic                           c3_unused_s;
`endif

    logic [NIB_BITS-1:0]            nib_a_s;
    logic [NIB_BITS-1:0]            nib_b_s;
    logic [NIB_BITS-1:0]            nib_s_s;
    logic                           nib_co_s;

    // Select the operand nibbles addressed by the step counter
    always_comb begin
        nib_a_s = a_q[cnt_q];
        nib_b_s = b_q[cnt_q];
    end

    cla4_slice u_slice (
        .a  (nib_a_s),
        .b  (nib_b_s),
        .ci (carry_q),
        .s  (nib_s_s),
        .co (nib_co_s),
`ifdef CLA_SEQ_OVF_EN
        .c3 (nib_c3_s)
`else
        .c3 (c3_unused_s)
`endif
    );

    // Controller next-state: accept, nibble stepping, completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef CLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    cnt_d   = {CNT_W{1'b0}};
                    s_d     = {WIDTH{1'b0}};
                    co_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                s_d[cnt_q] = nib_s_s;
                carry_d    = nib_co_s;
                if (cnt_q == LAST_CNT) begin
                    // Counter parks at the last step; the next accept clears it
                    state_d = S_DONE;
                    co_d    = nib_co_s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = nib_c3_s ^ nib_co_s;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
`ifdef CLA_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Directed scoreboard bench for cla_nibble_seq_adder (WIDTH=32); ovf checked when CLA_SEQ_OVF_EN is defined.
module tb_cla_nibble_seq_adder;

    localparam int W        = 32;
    localparam int NIB      = W / 4;
    localparam int MAX_WAIT = 40;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
`ifdef CLA_SEQ_OVF_EN
    logic         ovf;
`endif

    int   errors;
    int   checks;
    exp_t sb_q[$];

    cla_nibble_seq_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
        logic [W:0] sum;
        exp_t       e;
        sum   = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
        e.s   = sum[W-1:0];
        e.co  = sum[W];
        e.ovf = (aa[W-1] == bb[W-1]) && (sum[W-1] != aa[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_result();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'(1'b1), 64'(1'b0));
        end else begin
            e = sb_q.pop_front();
            chk("sum", 64'(s), 64'(e.s));
            chk("carry_out", 64'(co), 64'(e.co));
`ifdef CLA_SEQ_OVF_EN
            chk("overflow", 64'(ovf), 64'(e.ovf));
`endif
        end
    endtask

    task automatic run_add(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                           input int disturb_at);
        exp_t e;
        int   lat;
        @(negedge clk);
        a     = aa;
        b     = bb;
        ci    = cc;
        start = 1'b1;
        e     = model(aa, bb, cc);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        ci    = 1'b1;
        chk("busy_after_accept", 64'(busy), 64'(1'b1));
        lat = 0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(negedge clk);
            if (k == disturb_at) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            chk("busy_during_run", 64'(busy), 64'(1'b1));
        end
        start = 1'b0;
        chk("done_latency", 64'(lat), 64'(NIB));
        chk("busy_at_done", 64'(busy), 64'(1'b0));
        check_result();
        @(negedge clk);
        chk("done_single_cycle", 64'(done), 64'(1'b0));
        chk("sum_held", 64'(s), 64'(e.s));
        chk("co_held", 64'(co), 64'(e.co));
    endtask

    initial begin
        int t1;
        int t2;
        int seen;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        ci     = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(1'b0));
        chk("reset_done", 64'(done), 64'(1'b0));
        chk("reset_sum", 64'(s), 64'(0));
        chk("reset_co", 64'(co), 64'(1'b0));
`ifdef CLA_SEQ_OVF_EN
        chk("reset_ovf", 64'(ovf), 64'(1'b0));
`endif
        rst = 1'b0;

        run_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_add(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0);
        // A start pulse sampled at edge T3 must be ignored
        run_add(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 2);

        // Back-to-back: start held through the DONE cycle
        @(negedge clk);
        a     = 32'h0000_0005;
        b     = 32'h0000_0007;
        ci    = 1'b0;
        start = 1'b1;
        sb_q.push_back(model(32'h0000_0005, 32'h0000_0007, 1'b0));
        @(negedge clk);
        a = 32'hF000_0000;
        b = 32'h1000_0000;
        sb_q.push_back(model(32'hF000_0000, 32'h1000_0000, 1'b0));
        t1 = 0;
        t2 = 0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(negedge clk);
            if (t1 != 0 && k > t1) start = 1'b0;
            if (done === 1'b1) begin
                if (t1 == 0) begin
                    t1 = k;
                    check_result();
                end else begin
                    t2 = k;
                    check_result();
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_done", 64'(t1), 64'(NIB));
        chk("b2b_second_done", 64'(t2), 64'(2 * NIB + 1));

        // Reset in the middle of a RUN aborts it without a done pulse
        @(negedge clk);
        a     = 32'h1111_1111;
        b     = 32'h2222_2222;
        ci    = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("partial_sum_T3", 64'(s), 64'(32'h0000_0333));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(1'b0));
        chk("abort_done", 64'(done), 64'(1'b0));
        chk("abort_sum", 64'(s), 64'(0));
        chk("abort_co", 64'(co), 64'(1'b0));
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1;
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        run_add(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 0);

        // Signed-overflow corner operands
        run_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_add(32'h8000_0000, 32'h8000_0000, 1'b0, 0);

        for (int i = 0; i < 3; i++) begin
            run_add($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
        end

        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
